// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle ARM datapath, with memory wait states, Hold stall and illegal-opcode pulse.
// Optional cycle/instruction counters are enabled by defining MULTICYCLE_FSM_PERF_EN.
module multicycle_main_fsm #(
    parameter int MEM_WAIT = 0,
    parameter int WAIT_W   = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] Op,
    input  logic       FunctI,
    input  logic       FunctL,
    input  logic       Hold,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ALUOp,
    output logic       RegWEn,
    output logic       MemWEn,
    output logic       Branch,
    output logic       Illegal,
    output logic [3:0] State
`ifdef MULTICYCLE_FSM_PERF_EN
    ,
    output logic [31:0] CycleCount,
    output logic [31:0] InstrCount
`endif
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_WAIT);

    state_t            state_r;
    state_t            next_state_s;
    logic [WAIT_W-1:0] cnt_r;
    logic [WAIT_W-1:0] next_cnt_s;
    logic              mem_state_s;
    logic              last_s;
    logic              strobe_en_s;

    assign mem_state_s = (state_r == FETCH) || (state_r == MEMREAD) || (state_r == MEMWRITE);
    assign last_s      = (cnt_r == WAIT_MAX);
    // Strobes are also masked during reset so FETCH does not pulse IRWrite while RESET is held.
    assign strobe_en_s = !Hold && !RESET;
    assign State       = state_r;

    // State and wait-counter register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= FETCH;
            cnt_r   <= {WAIT_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            cnt_r   <= next_cnt_s;
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        if (Hold) begin
            next_state_s = state_r;
            next_cnt_s   = cnt_r;
        end else if (mem_state_s && !last_s) begin
            next_cnt_s = cnt_r + WAIT_W'(1);
        end else begin
            next_cnt_s = {WAIT_W{1'b0}};
            case (state_r)
                FETCH:    next_state_s = DECODE;
                DECODE: begin
                    case (Op)
                        2'b00:   next_state_s = FunctI ? EXECUTEI : EXECUTER;
                        2'b01:   next_state_s = MEMADR;
                        2'b10:   next_state_s = BRANCH;
                        default: next_state_s = FETCH;
                    endcase
                end
                MEMADR:   next_state_s = FunctL ? MEMREAD : MEMWRITE;
                MEMREAD:  next_state_s = MEMWB;
                MEMWB:    next_state_s = FETCH;
                MEMWRITE: next_state_s = FETCH;
                EXECUTER: next_state_s = ALUWB;
                EXECUTEI: next_state_s = ALUWB;
                ALUWB:    next_state_s = FETCH;
                BRANCH:   next_state_s = FETCH;
                default:  next_state_s = FETCH;
            endcase
        end
    end

    // Moore datapath selects and strobes; strobes gated by Hold, reset and the final wait cycle.
    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = 1'b0;
        RegWEn    = 1'b0;
        MemWEn    = 1'b0;
        Branch    = 1'b0;
        Illegal   = 1'b0;
        case (state_r)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = strobe_en_s && last_s;
                NextPC    = strobe_en_s && last_s;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                Illegal   = strobe_en_s && (Op == 2'b11);
            end
            MEMADR:   ALUSrcB = 2'b01;
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWEn    = strobe_en_s;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                MemWEn = strobe_en_s && last_s;
            end
            EXECUTER: ALUOp = 1'b1;
            EXECUTEI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            ALUWB:    RegWEn = strobe_en_s;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = strobe_en_s;
            end
            default: begin
                IRWrite = 1'b0;
            end
        endcase
    end

`ifdef MULTICYCLE_FSM_PERF_EN
    logic [31:0] cycle_cnt_r;
    logic [31:0] instr_cnt_r;

    assign CycleCount = cycle_cnt_r;
    assign InstrCount = instr_cnt_r;

    // Free-running cycle counter and fetched-instruction counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cycle_cnt_r <= 32'd0;
            instr_cnt_r <= 32'd0;
        end else begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
            if (IRWrite) begin
                instr_cnt_r <= instr_cnt_r + 32'd1;
            end else begin
                instr_cnt_r <= instr_cnt_r;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Scoreboard bench for multicycle_main_fsm: three instances with MEM_WAIT = 0, 1, 2 share the inputs.
module tb_multicycle_main_fsm;

    logic       CLK;
    logic       RESET;
    logic [1:0] Op;
    logic       FunctI;
    logic       FunctL;
    logic       Hold;

    logic       irw_o [3];
    logic       npc_o [3];
    logic       adr_o [3];
    logic [1:0] rs_o  [3];
    logic       sa_o  [3];
    logic [1:0] sb_o  [3];
    logic       aop_o [3];
    logic       rw_o  [3];
    logic       mw_o  [3];
    logic       br_o  [3];
    logic       il_o  [3];
    logic [3:0] st_o  [3];
`ifdef MULTICYCLE_FSM_PERF_EN
    logic [31:0] cyc_o [3];
    logic [31:0] ins_o [3];
`endif

    for (genvar g = 0; g < 3; g++) begin : g_dut
        multicycle_main_fsm #(.MEM_WAIT(g), .WAIT_W(4)) u_dut (
            .CLK(CLK), .RESET(RESET), .Op(Op), .FunctI(FunctI), .FunctL(FunctL), .Hold(Hold),
            .IRWrite(irw_o[g]), .NextPC(npc_o[g]), .AdrSrc(adr_o[g]), .ResultSrc(rs_o[g]),
            .ALUSrcA(sa_o[g]), .ALUSrcB(sb_o[g]), .ALUOp(aop_o[g]), .RegWEn(rw_o[g]),
            .MemWEn(mw_o[g]), .Branch(br_o[g]), .Illegal(il_o[g]), .State(st_o[g])
`ifdef MULTICYCLE_FSM_PERF_EN
            , .CycleCount(cyc_o[g]), .InstrCount(ins_o[g])
`endif
        );
    end

    typedef struct packed {
        logic        hold;
        logic [1:0]  op;
        logic        fi;
        logic        fl;
        logic [16:0] v;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic logic [16:0] obs(int k);
        return {st_o[k], irw_o[k], npc_o[k], adr_o[k], rs_o[k], sa_o[k], sb_o[k],
                aop_o[k], rw_o[k], mw_o[k], br_o[k], il_o[k]};
    endfunction

    // Expected outputs straight from the state output table.
    function automatic logic [16:0] exp_vec(logic [3:0] st, logic fin, logic hold, logic [1:0] op);
        logic irw, npc, adr, sa, aop, rw, mw, br, il;
        logic [1:0] rs, sb;
        {irw, npc, adr, sa, aop, rw, mw, br, il} = 9'd0;
        rs = 2'b00;
        sb = 2'b00;
        case (st)
            4'd0: begin sa = 1'b1; sb = 2'b10; rs = 2'b10; irw = fin; npc = fin; end
            4'd1: begin sa = 1'b1; sb = 2'b10; rs = 2'b10; il = (op == 2'b11); end
            4'd2: sb = 2'b01;
            4'd3: adr = 1'b1;
            4'd4: begin rs = 2'b01; rw = 1'b1; end
            4'd5: begin adr = 1'b1; mw = fin; end
            4'd6: aop = 1'b1;
            4'd7: begin sb = 2'b01; aop = 1'b1; end
            4'd8: rw = 1'b1;
            4'd9: begin sb = 2'b01; rs = 2'b10; br = 1'b1; end
            default: ;
        endcase
        if (hold) {irw, npc, rw, mw, br, il} = 6'd0;
        return {st, irw, npc, adr, rs, sa, sb, aop, rw, mw, br, il};
    endfunction

    task automatic push(logic [3:0] st, logic fin, logic hold, logic [1:0] op, logic fi, logic fl);
        q.push_back('{hold, op, fi, fl, exp_vec(st, fin, hold, op)});
    endtask

    task automatic push_mem(logic [3:0] st, int w, logic [1:0] op, logic fi, logic fl);
        for (int i = 0; i <= w; i++) push(st, (i == w), 1'b0, op, fi, fl);
    endtask

    // Expected per-cycle sequence of one instruction derived from the transition list.
    task automatic push_instr(int w, logic [1:0] op, logic fi, logic fl);
        push_mem(4'd0, w, op, fi, fl);
        push(4'd1, 1'b1, 1'b0, op, fi, fl);
        case (op)
            2'b00: begin
                push(fi ? 4'd7 : 4'd6, 1'b1, 1'b0, op, fi, fl);
                push(4'd8, 1'b1, 1'b0, op, fi, fl);
            end
            2'b01: begin
                push(4'd2, 1'b1, 1'b0, op, fi, fl);
                if (fl) begin
                    push_mem(4'd3, w, op, fi, fl);
                    push(4'd4, 1'b1, 1'b0, op, fi, fl);
                end else begin
                    push_mem(4'd5, w, op, fi, fl);
                end
            end
            2'b10: push(4'd9, 1'b1, 1'b0, op, fi, fl);
            default: ;
        endcase
    endtask

    task automatic do_reset();
        Hold = 1'b0;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        Hold = 1'b0;
        Op = 2'b00;
        FunctI = 1'b0;
        FunctL = 1'b0;
        @(negedge CLK);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs(k) !== exp_vec(4'd0, 1'b1, 1'b1, 2'b00)) begin
                errors++;
                $display("FAIL reset_state dut%0d got=%h exp=%h", k, obs(k), exp_vec(4'd0, 1'b1, 1'b1, 2'b00));
            end
`ifdef MULTICYCLE_FSM_PERF_EN
            checks++;
            if (cyc_o[k] !== 32'd0 || ins_o[k] !== 32'd0) begin
                errors++;
                $display("FAIL reset_perf dut%0d got=%0d/%0d exp=0/0", k, cyc_o[k], ins_o[k]);
            end
`endif
        end
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic test_ldr();
        int n = 0;
        do_reset();
        push_instr(0, 2'b01, 1'b0, 1'b1);
        push(4'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        while (q.size() > 0) begin
            Op = q[0].op; FunctI = q[0].fi; FunctL = q[0].fl; Hold = q[0].hold;
            @(negedge CLK);
            checks++;
            if (obs(0) !== q[0].v) begin
                errors++;
                $display("FAIL ldr_w0 cyc%0d got=%h exp=%h", n, obs(0), q[0].v);
            end
            void'(q.pop_front());
            n++;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_str_wait();
        int n = 0;
        do_reset();
        push_instr(2, 2'b01, 1'b0, 1'b0);
        push(4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        while (q.size() > 0) begin
            Op = q[0].op; FunctI = q[0].fi; FunctL = q[0].fl; Hold = q[0].hold;
            @(negedge CLK);
            checks++;
            if (obs(2) !== q[0].v) begin
                errors++;
                $display("FAIL str_w2 cyc%0d got=%h exp=%h", n, obs(2), q[0].v);
            end
            void'(q.pop_front());
            n++;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_back_to_back_dp();
        int n = 0;
        do_reset();
        push_instr(0, 2'b00, 1'b1, 1'b0);
        push_instr(0, 2'b00, 1'b0, 1'b0);
        push_instr(0, 2'b11, 1'b0, 1'b0);
        push(4'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        while (q.size() > 0) begin
            Op = q[0].op; FunctI = q[0].fi; FunctL = q[0].fl; Hold = q[0].hold;
            @(negedge CLK);
            checks++;
            if (obs(0) !== q[0].v) begin
                errors++;
                $display("FAIL dp_illegal cyc%0d got=%h exp=%h", n, obs(0), q[0].v);
            end
            void'(q.pop_front());
            n++;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_hold();
        int n = 0;
        do_reset();
        push(4'd0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push(4'd0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
        push(4'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
        push(4'd1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
        push(4'd9, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
        push(4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        while (q.size() > 0) begin
            Op = q[0].op; FunctI = q[0].fi; FunctL = q[0].fl; Hold = q[0].hold;
            @(negedge CLK);
            checks++;
            if (obs(1) !== q[0].v) begin
                errors++;
                $display("FAIL hold_w1 cyc%0d got=%h exp=%h", n, obs(1), q[0].v);
            end
            void'(q.pop_front());
            n++;
            @(posedge CLK);
            #1;
        end
        Hold = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        push(4'd0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1);
        push(4'd1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1);
        push(4'd2, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1);
        while (q.size() > 0) begin
            Op = q[0].op; FunctI = q[0].fi; FunctL = q[0].fl; Hold = q[0].hold;
            @(negedge CLK);
            checks++;
            if (obs(0) !== q[0].v) begin
                errors++;
                $display("FAIL rstmid_pre cyc%0d got=%h exp=%h", n, obs(0), q[0].v);
            end
            void'(q.pop_front());
            n++;
            @(posedge CLK);
            #1;
        end
        #2;
        checks++;
        if (st_o[0] !== 4'd3) begin
            errors++;
            $display("FAIL rstmid_in_memread got=%0d exp=3", st_o[0]);
        end
        RESET = 1'b1;
        #1;
        checks++;
        if (obs(0) !== exp_vec(4'd0, 1'b1, 1'b1, 2'b01)) begin
            errors++;
            $display("FAIL rstmid_async got=%h exp=%h", obs(0), exp_vec(4'd0, 1'b1, 1'b1, 2'b01));
        end
`ifdef MULTICYCLE_FSM_PERF_EN
        checks++;
        if (cyc_o[0] !== 32'd0 || ins_o[0] !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_perf got=%0d/%0d exp=0/0", cyc_o[0], ins_o[0]);
        end
`endif
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        push_instr(0, 2'b10, 1'b0, 1'b0);
        for (int pass = 0; pass < 2; pass++) begin
            while (q.size() > 0) begin
                Op = q[0].op; FunctI = q[0].fi; FunctL = q[0].fl; Hold = q[0].hold;
                @(negedge CLK);
                checks++;
                if (obs(0) !== q[0].v) begin
                    errors++;
                    $display("FAIL rstmid_branch cyc%0d got=%h exp=%h", n, obs(0), q[0].v);
                end
                void'(q.pop_front());
                n++;
                @(posedge CLK);
                #1;
            end
`ifdef MULTICYCLE_FSM_PERF_EN
            if (pass == 0) begin
                checks++;
                if (ins_o[0] !== 32'd1 || cyc_o[0] !== 32'd3) begin
                    errors++;
                    $display("FAIL rstmid_counts got=%0d/%0d exp=1/3", ins_o[0], cyc_o[0]);
                end
            end
`endif
            if (pass == 0) push(4'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_ldr();
        test_str_wait();
        test_back_to_back_dp();
        test_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
